// File: rtl/timer_ctrl_if.sv
// ---------------------------------------------------------------------------
// timer_ctrl_if
//   Control/status bundle between the register block (master) and the
//   interval timer controller (slave).
//
//   master drives : i_start, i_stop, i_pause, i_period, i_mode, i_irq_ack
//   slave drives  : o_cnt, o_busy, o_tick, o_done, o_irq, o_miss
//
//   CNT_W and MISS_W must match the parameters of the attached timer_ctrl.
// ---------------------------------------------------------------------------
interface timer_ctrl_if #(
    parameter int CNT_W  = 8,
    parameter int MISS_W = 4
);
    logic              i_start;
    logic              i_stop;
    logic              i_pause;
    logic [CNT_W-1:0]  i_period;
    logic              i_mode;
    logic              i_irq_ack;

    logic [CNT_W-1:0]  o_cnt;
    logic              o_busy;
    logic              o_tick;
    logic              o_done;
    logic              o_irq;
    logic [MISS_W-1:0] o_miss;

    modport master (
        output i_start, i_stop, i_pause, i_period, i_mode, i_irq_ack,
        input  o_cnt, o_busy, o_tick, o_done, o_irq, o_miss
    );

    modport slave (
        input  i_start, i_stop, i_pause, i_period, i_mode, i_irq_ack,
        output o_cnt, o_busy, o_tick, o_done, o_irq, o_miss
    );
endinterface

// File: rtl/timer_ctrl.sv
// ---------------------------------------------------------------------------
// timer_ctrl
//   Programmable interval timer: modulo up-counter 0..P with one-shot or
//   periodic operation, level pause, one-cycle terminal tick, sticky
//   interrupt with acknowledge and a saturating missed-interrupt counter.
//
//   Ports
//     i_clk   : clock, rising edge
//     i_rstn  : asynchronous active-low reset
//     bus     : timer_ctrl_if.slave (start/stop/pause/period/mode/irq_ack in,
//               cnt/busy/tick/done/irq/miss out, all outputs registered)
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | stopped, count 0, waiting for start
//   ST_RUN   | counting towards the latched period
//   ST_PAUSE | count frozen while i_pause is high
//   ST_DONE  | one-shot finished, count holds P until start or stop
// ---------------------------------------------------------------------------
module timer_ctrl #(
    parameter int CNT_W  = 8,
    parameter int MISS_W = 4
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    timer_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [MISS_W-1:0] MISS_MAX = '1;

    state_t            state_q, state_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic [CNT_W-1:0]  period_q, period_nxt;
    logic              mode_q, mode_nxt;
    logic              tick_q, tick_nxt;
    logic              busy_q, done_q;
    logic              irq_q, irq_nxt;
    logic [MISS_W-1:0] miss_q, miss_nxt;
    logic              term;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            mode_q   <= 1'b0;
            tick_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            irq_q    <= 1'b0;
            miss_q   <= '0;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            period_q <= period_nxt;
            mode_q   <= mode_nxt;
            tick_q   <= tick_nxt;
            busy_q   <= (state_nxt == ST_RUN) || (state_nxt == ST_PAUSE);
            done_q   <= (state_nxt == ST_DONE);
            irq_q    <= irq_nxt;
            miss_q   <= miss_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q;
        period_nxt = period_q;
        mode_nxt   = mode_q;
        tick_nxt   = 1'b0;
        term       = 1'b0;

        if (bus.i_stop) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.i_start) begin
                        period_nxt = bus.i_period;
                        mode_nxt   = bus.i_mode;
                        cnt_nxt    = '0;
                        state_nxt  = ST_RUN;
                    end
                end
                // Leaving PAUSE counts in the same cycle, so a pause of N
                // cycles delays the next terminal event by exactly N.
                ST_RUN, ST_PAUSE: begin
                    if (bus.i_pause) begin
                        state_nxt = ST_PAUSE;
                    end else if (cnt_q == period_q) begin
                        term     = 1'b1;
                        tick_nxt = 1'b1;
                        if (mode_q) begin
                            cnt_nxt   = '0;
                            state_nxt = ST_RUN;
                        end else begin
                            state_nxt = ST_DONE;
                        end
                    end else begin
                        cnt_nxt   = cnt_q + CNT_W'(1);
                        state_nxt = ST_RUN;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // A terminal event beats a simultaneous ack for o_irq; the ack still
    // clears the miss count.
    always_comb begin
        irq_nxt  = irq_q;
        miss_nxt = miss_q;
        if (term) begin
            irq_nxt = 1'b1;
            if (bus.i_irq_ack) begin
                miss_nxt = '0;
            end else if (irq_q && (miss_q != MISS_MAX)) begin
                miss_nxt = miss_q + MISS_W'(1);
            end
        end else if (bus.i_irq_ack) begin
            irq_nxt  = 1'b0;
            miss_nxt = '0;
        end
    end

    assign bus.o_cnt  = cnt_q;
    assign bus.o_busy = busy_q;
    assign bus.o_tick = tick_q;
    assign bus.o_done = done_q;
    assign bus.o_irq  = irq_q;
    assign bus.o_miss = miss_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timer_ctrl
//   Self-checking bench for timer_ctrl. A behavioural model (session flags,
//   modulo arithmetic on the count) predicts every output after each clock
//   edge; scenario tasks add directed checks on the documented boundaries.
// ---------------------------------------------------------------------------
module tb_timer_ctrl;

    localparam int CNT_W    = 8;
    localparam int MISS_W   = 4;
    localparam int MISS_SAT = (1 << MISS_W) - 1;

    typedef logic [CNT_W+MISS_W+3:0] vec_t;

    logic i_clk  = 1'b0;
    logic i_rstn = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    timer_ctrl_if #(.CNT_W(CNT_W), .MISS_W(MISS_W)) bus ();

    timer_ctrl #(.CNT_W(CNT_W), .MISS_W(MISS_W)) dut (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .bus    (bus)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- reference model ----------------
    bit m_active, m_done, m_tick, m_irq, m_mode;
    int m_cnt, m_per, m_miss;

    function automatic void model_reset();
        m_active = 0; m_done = 0; m_tick = 0; m_irq = 0; m_mode = 0;
        m_cnt = 0; m_per = 0; m_miss = 0;
    endfunction

    function automatic void model_step();
        bit term;
        term   = 0;
        m_tick = 0;
        if (bus.i_stop) begin
            m_active = 0; m_done = 0; m_cnt = 0;
        end else if (!m_active) begin
            if (bus.i_start) begin
                m_per = int'(bus.i_period); m_mode = bus.i_mode;
                m_cnt = 0; m_active = 1; m_done = 0;
            end
        end else if (!bus.i_pause) begin
            if (m_cnt == m_per) begin
                term = 1; m_tick = 1;
                if (!m_mode) begin m_active = 0; m_done = 1; end
            end
            if (m_mode) m_cnt = (m_cnt + 1) % (m_per + 1);
            else if (!term) m_cnt = m_cnt + 1;
        end
        if (term) begin
            if (bus.i_irq_ack) m_miss = 0;
            else if (m_irq) m_miss = (m_miss + 1 > MISS_SAT) ? MISS_SAT : m_miss + 1;
            m_irq = 1;
        end else if (bus.i_irq_ack) begin
            m_irq = 0; m_miss = 0;
        end
    endfunction

    function automatic vec_t exp_vec();
        return {CNT_W'(m_cnt), m_active, m_tick, m_done, m_irq, MISS_W'(m_miss)};
    endfunction

    function automatic vec_t obs_vec();
        return {bus.o_cnt, bus.o_busy, bus.o_tick, bus.o_done, bus.o_irq, bus.o_miss};
    endfunction

    function automatic string fields(vec_t v);
        return $sformatf("cnt=%0d busy=%0b tick=%0b done=%0b irq=%0b miss=%0d",
                         v[MISS_W+CNT_W+3:MISS_W+4], v[MISS_W+3], v[MISS_W+2],
                         v[MISS_W+1], v[MISS_W], v[MISS_W-1:0]);
    endfunction

    task automatic cycle();
        @(posedge i_clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_start = 0; bus.i_stop = 0; bus.i_pause = 0;
        bus.i_period = '0; bus.i_mode = 0; bus.i_irq_ack = 0;
    endtask

    task automatic start(input int p, input bit mode);
        bus.i_start = 1; bus.i_period = CNT_W'(p); bus.i_mode = mode;
        cycle();
        bus.i_start = 0;
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL start: got %s, expected %s", fields(obs_vec()), fields(exp_vec()));
        end
    endtask

    task automatic go_idle();
        bus.i_stop = 1; bus.i_irq_ack = 1;
        cycle();
        clear_inputs();
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL go_idle: got %s, expected %s", fields(obs_vec()), fields(exp_vec()));
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        model_reset();
        #2;
        n_checks++;
        if (obs_vec() !== vec_t'(0)) begin
            n_fail++;
            $display("FAIL reset_values: got %s, expected all zero", fields(obs_vec()));
        end
        @(negedge i_clk);
        i_rstn = 1;
        cycle();
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_idle: got %s, expected %s", fields(obs_vec()), fields(exp_vec()));
        end
    endtask

    task automatic test_periodic();
        int ticks = 0;
        start(3, 1);
        for (int i = 1; i <= 12; i++) begin
            cycle();
            n_checks++;
            if (obs_vec() !== exp_vec() || bus.o_cnt !== CNT_W'(i % 4)) begin
                n_fail++;
                $display("FAIL periodic cyc%0d: got %s, expected %s", i, fields(obs_vec()), fields(exp_vec()));
            end
            if (bus.o_tick) ticks++;
        end
        n_checks++;
        if (ticks != 3 || bus.o_irq !== 1'b1 || bus.o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL periodic_summary: got ticks=%0d irq=%0b busy=%0b, expected ticks=3 irq=1 busy=1",
                     ticks, bus.o_irq, bus.o_busy);
        end
        go_idle();
    endtask

    task automatic test_oneshot();
        int tick_at = -1;
        start(5, 0);
        for (int i = 1; i <= 9; i++) begin
            cycle();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL oneshot cyc%0d: got %s, expected %s", i, fields(obs_vec()), fields(exp_vec()));
            end
            if (bus.o_tick) tick_at = (tick_at == -1) ? i : -2;
        end
        n_checks++;
        if (tick_at != 6 || bus.o_cnt !== CNT_W'(5) || bus.o_done !== 1'b1 || bus.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_done: got tick_at=%0d cnt=%0d done=%0b busy=%0b, expected 6 5 1 0",
                     tick_at, bus.o_cnt, bus.o_done, bus.o_busy);
        end
        start(5, 0);
        n_checks++;
        if (bus.o_cnt !== '0 || bus.o_busy !== 1'b1 || bus.o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_restart: got cnt=%0d busy=%0b done=%0b, expected 0 1 0",
                     bus.o_cnt, bus.o_busy, bus.o_done);
        end
        go_idle();
    endtask

    task automatic test_pause();
        int n = 0;
        start(7, 1);
        for (int k = 0; k < 20 && bus.o_cnt !== CNT_W'(4); k++) cycle();
        bus.i_pause = 1;
        for (int i = 0; i < 3; i++) begin
            cycle(); n++;
            n_checks++;
            if (obs_vec() !== exp_vec() || bus.o_cnt !== CNT_W'(4)) begin
                n_fail++;
                $display("FAIL pause_hold%0d: got %s, expected %s", i, fields(obs_vec()), fields(exp_vec()));
            end
        end
        bus.i_pause = 0;
        for (int k = 0; k < 20 && !bus.o_tick; k++) begin
            cycle(); n++;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL pause_resume: got %s, expected %s", fields(obs_vec()), fields(exp_vec()));
            end
        end
        n_checks++;
        if (n != 7 || bus.o_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_delay: got %0d cycles to tick, expected 7", n);
        end
        go_idle();
    endtask

    task automatic test_miss();
        start(1, 1);
        for (int i = 0; i < 40; i++) begin
            cycle();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL miss_run%0d: got %s, expected %s", i, fields(obs_vec()), fields(exp_vec()));
            end
        end
        n_checks++;
        if (bus.o_irq !== 1'b1 || bus.o_miss !== MISS_W'(MISS_SAT)) begin
            n_fail++;
            $display("FAIL miss_saturate: got irq=%0b miss=%0d, expected 1 %0d", bus.o_irq, bus.o_miss, MISS_SAT);
        end
        bus.i_irq_ack = 1;
        cycle();
        bus.i_irq_ack = 0;
        n_checks++;
        if (obs_vec() !== exp_vec() || bus.o_irq !== 1'b0 || bus.o_miss !== '0) begin
            n_fail++;
            $display("FAIL ack_clear: got %s, expected %s", fields(obs_vec()), fields(exp_vec()));
        end
        cycle();
        cycle();
        bus.i_irq_ack = 1;
        cycle();
        bus.i_irq_ack = 0;
        n_checks++;
        if (obs_vec() !== exp_vec() || bus.o_tick !== 1'b1 || bus.o_irq !== 1'b1 || bus.o_miss !== '0) begin
            n_fail++;
            $display("FAIL ack_with_event: got %s, expected %s", fields(obs_vec()), fields(exp_vec()));
        end
        go_idle();
    endtask

    task automatic test_stop();
        start(5, 1);
        cycle();
        bus.i_start = 1; bus.i_period = CNT_W'(2); bus.i_mode = 0;
        cycle();
        bus.i_start = 0;
        n_checks++;
        if (obs_vec() !== exp_vec() || bus.o_cnt !== CNT_W'(2)) begin
            n_fail++;
            $display("FAIL start_in_run: got %s, expected %s", fields(obs_vec()), fields(exp_vec()));
        end
        for (int k = 0; k < 20 && !bus.o_tick; k++) cycle();
        for (int k = 0; k < 20 && bus.o_cnt !== CNT_W'(5); k++) cycle();
        n_checks++;
        if (obs_vec() !== exp_vec() || bus.o_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_setup: got %s, expected %s", fields(obs_vec()), fields(exp_vec()));
        end
        bus.i_stop = 1;
        cycle();
        bus.i_stop = 0;
        n_checks++;
        if (obs_vec() !== exp_vec() || bus.o_cnt !== '0 || bus.o_tick !== 1'b0 ||
            bus.o_busy !== 1'b0 || bus.o_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_at_terminal: got %s, expected %s", fields(obs_vec()), fields(exp_vec()));
        end
        go_idle();
    endtask

    task automatic test_back_to_back();
        start(0, 1);
        for (int i = 0; i < 6; i++) begin
            cycle();
            n_checks++;
            if (obs_vec() !== exp_vec() || bus.o_tick !== 1'b1 || bus.o_cnt !== '0) begin
                n_fail++;
                $display("FAIL p0_periodic%0d: got %s, expected %s", i, fields(obs_vec()), fields(exp_vec()));
            end
        end
        go_idle();
        start(0, 0);
        cycle();
        n_checks++;
        if (obs_vec() !== exp_vec() || bus.o_tick !== 1'b1 || bus.o_done !== 1'b1) begin
            n_fail++;
            $display("FAIL p0_oneshot: got %s, expected %s", fields(obs_vec()), fields(exp_vec()));
        end
        go_idle();
    endtask

    task automatic test_async_reset();
        start(9, 1);
        for (int k = 0; k < 20 && bus.o_cnt !== CNT_W'(6); k++) cycle();
        #2;
        i_rstn = 0;
        #1;
        model_reset();
        n_checks++;
        if (obs_vec() !== vec_t'(0)) begin
            n_fail++;
            $display("FAIL async_reset: got %s, expected all zero", fields(obs_vec()));
        end
        @(negedge i_clk);
        @(negedge i_clk);
        i_rstn = 1;
        cycle();
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %s, expected %s", fields(obs_vec()), fields(exp_vec()));
        end
        start(2, 1);
        go_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            bus.i_stop    = ($urandom_range(0, 99) < 3);
            bus.i_start   = ($urandom_range(0, 99) < 10);
            bus.i_pause   = ($urandom_range(0, 99) < 15);
            bus.i_irq_ack = ($urandom_range(0, 99) < 8);
            bus.i_mode    = 1'($urandom_range(0, 1));
            bus.i_period  = CNT_W'($urandom_range(0, 9));
            cycle();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random%0d: got %s, expected %s", i, fields(obs_vec()), fields(exp_vec()));
            end
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_pause();
        test_miss();
        test_stop();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
